// File: rtl/softmax_accumulate_pkg.sv
// Shared types and fixed-point constants for the online-softmax accumulation stage.
// Default sizing macros may be overridden on the command line.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef LOG2E_SHIFT_HALF
`define LOG2E_SHIFT_HALF 1
`endif
`ifndef LOG2E_SHIFT_SIXTEENTH
`define LOG2E_SHIFT_SIXTEENTH 4
`endif

package softmax_accumulate_pkg;
   localparam int EXPMUL_DIFF_IN_I = 5;
   localparam int EXPMUL_DIFF_IN_F = 4;
   localparam int S_W              = EXPMUL_DIFF_IN_I + EXPMUL_DIFF_IN_F;
   localparam int DIFF_W           = S_W + 1;
   localparam int EXP_W            = 8;
   localparam int EXP_FRAC         = 7;
   localparam int V_W              = 8;
   localparam int PV_W             = 17;
   localparam int LOG2E_SHIFT_A    = `LOG2E_SHIFT_HALF;
   localparam int LOG2E_SHIFT_B    = `LOG2E_SHIFT_SIXTEENTH;

   typedef logic signed [S_W-1:0]    EXPMUL_DIFF_IN_QT;
   typedef logic signed [DIFF_W-1:0] EXP_DIFF_QT;
   typedef logic [EXP_W-1:0]         EXP_QT;
   typedef logic signed [V_W-1:0]    V_QT;
   typedef V_QT [`MAX_EMBEDDING_DIM-1:0] V_VECTOR_T;
   typedef logic signed [PV_W-1:0]   PV_PRODUCT_QT;

   localparam int O_ACC_W = PV_W + $clog2(`MAX_SEQ_LENGTH);
   localparam int L_ACC_W = EXP_W + $clog2(`MAX_SEQ_LENGTH);
   typedef logic signed [O_ACC_W-1:0] O_ACC_QT;
   typedef O_ACC_QT [`MAX_EMBEDDING_DIM-1:0] O_ACC_VECTOR_T;
   typedef logic [L_ACC_W-1:0] L_ACC_QT;
endpackage

// File: rtl/softmax_accumulate_exp2_approx.sv
// exp2_approx: e^d for d <= 0 (Q5.4, 10b) as unsigned Q1.7 via 2^(d*log2e).
// SOFTMAX_EXP_ROUND_EN selects round-half-up on the final shift instead of truncation.
module exp2_approx
   import softmax_accumulate_pkg::*;
(
   input  logic [DIFF_W-1:0] d,
   output logic [EXP_W-1:0]  e
);

   logic signed [DIFF_W+1:0] dx;
   logic signed [DIFF_W+1:0] y;
   logic [7:0]               sh;
   logic [8:0]               mant;

   always_comb begin
      dx   = {{2{d[DIFF_W-1]}}, d};
      // y = d*log2e with 4 fractional bits; integer part gives the shift, fraction the mantissa
      y    = dx + (dx >>> LOG2E_SHIFT_A) - (dx >>> LOG2E_SHIFT_B);
      sh   = 8'(-(y >>> 4));
      mant = 9'd128 + {2'b00, y[3:0], 3'b000};
      e    = '0;
      if (sh < 8'd8) begin
`ifdef SOFTMAX_EXP_ROUND_EN
         if (sh != 8'd0) mant = mant + (9'd1 << (sh - 8'd1));
`endif
         e = 8'(mant >> sh[2:0]);
      end
   end

endmodule

// File: rtl/softmax_accumulate.sv
// Online-softmax accumulation: running max, exp-sum and weighted V sum per query, emitted
// after SEQ_LEN rows. Exp rounding is selected by SOFTMAX_EXP_ROUND_EN inside exp2_approx.
module softmax_accumulate
   import softmax_accumulate_pkg::*;
#(
   parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
   parameter int DIM     = `MAX_EMBEDDING_DIM,
   localparam int OW     = PV_W + $clog2(SEQ_LEN),
   localparam int LW     = EXP_W + $clog2(SEQ_LEN)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_in,
   output logic               rdy_out,
   input  logic [S_W-1:0]     s_in,
   input  logic [DIM*V_W-1:0] v_in,
   input  logic               rdy_in,
   output logic               vld_out,
   output logic [DIM*OW-1:0]  o_out,
   output logic [LW-1:0]      l_out
);

   localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);
   localparam int OPW = OW + EXP_W + 1;
   localparam int LPW = LW + EXP_W;

   logic               stall, acc, first, last;
   EXPMUL_DIFF_IN_QT   s, m, m_new;
   logic [CNT_W-1:0]   cnt;

   logic               vld_a, first_a, last_a;
   EXP_DIFF_QT         d_a, d_p;
   logic [DIM*V_W-1:0] v_a;

   logic               vld_b, first_b, last_b;
   EXP_QT              alpha, p, alpha_b, p_b;
   logic [DIM*V_W-1:0] v_b;

   logic [DIM*OW-1:0]  o_acc, o_nxt;
   logic [LW-1:0]      l_acc, l_nxt;
   PV_PRODUCT_QT       pv [DIM];

   assign stall   = vld_out && !rdy_in;
   assign rdy_out = !stall;
   assign acc     = vld_in && rdy_out;
   assign s       = s_in;
   assign first   = (cnt == '0);
   assign last    = (cnt == CNT_LAST);
   assign m_new   = (first || s > m) ? s : m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m       <= '0;
         cnt     <= '0;
         vld_a   <= 1'b0;
         first_a <= 1'b0;
         last_a  <= 1'b0;
         d_a     <= '0;
         d_p     <= '0;
         v_a     <= '0;
      end else if (!stall) begin
         vld_a <= acc;
         if (acc) begin
            m       <= m_new;
            cnt     <= last ? '0 : cnt + 1'b1;
            d_a     <= {m[S_W-1], m} - {m_new[S_W-1], m_new};
            d_p     <= {s[S_W-1], s} - {m_new[S_W-1], m_new};
            v_a     <= v_in;
            first_a <= first;
            last_a  <= last;
         end
      end
   end

   exp2_approx u_exp_alpha (.d(d_a), .e(alpha));
   exp2_approx u_exp_p     (.d(d_p), .e(p));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_b   <= 1'b0;
         first_b <= 1'b0;
         last_b  <= 1'b0;
         alpha_b <= '0;
         p_b     <= '0;
         v_b     <= '0;
      end else if (!stall) begin
         vld_b <= vld_a;
         if (vld_a) begin
            alpha_b <= alpha;
            p_b     <= p;
            v_b     <= v_a;
            first_b <= first_a;
            last_b  <= last_a;
         end
      end
   end

   // Rescale the running sums by alpha and add the new p-weighted row.
   always_comb begin
      o_nxt = '0;
      pv    = '{default: '0};
      for (int j = 0; j < DIM; j++) begin
         pv[j] = $signed(PV_W'({1'b0, p_b})) * $signed(PV_W'($signed(v_b[j*V_W +: V_W])));
         o_nxt[j*OW +: OW] = first_b ? OW'(pv[j]) :
            OW'((OPW'($signed(o_acc[j*OW +: OW])) * OPW'($signed({1'b0, alpha_b}))) >>> EXP_FRAC)
            + OW'(pv[j]);
      end
      l_nxt = first_b ? LW'(p_b) :
         LW'((LPW'(l_acc) * LPW'(alpha_b)) >> EXP_FRAC) + LW'(p_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_acc   <= '0;
         l_acc   <= '0;
         o_out   <= '0;
         l_out   <= '0;
         vld_out <= 1'b0;
      end else if (!stall) begin
         vld_out <= vld_b && last_b;
         if (vld_b) begin
            if (last_b) begin
               o_out <= o_nxt;
               l_out <= l_nxt;
               o_acc <= '0;
               l_acc <= '0;
            end else begin
               o_acc <= o_nxt;
               l_acc <= l_nxt;
            end
         end
      end
   end

endmodule
